// File: rtl/flyer_spawner.sv
// Wave/spawn controller for the three enemy flyer slots: paces spawns, confirms them
// against flyer_exists, counts kills and raises the wave. Optional burst spawning: FLYER_BURST_EN.
module flyer_spawner #(
  parameter logic [7:0]  INT_EASY   = 8'd120,
  parameter logic [7:0]  INT_NORMAL = 8'd90,
  parameter logic [7:0]  INT_HARD   = 8'd60,
  parameter logic [7:0]  INT_FLOOR  = 8'd30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       run,
  input  logic [2:0] difficulty,
  input  logic [2:0] flyer_exists,
  input  logic [2:0] flyer_explosion,
  output logic [2:0] spawn,
  output logic [7:0] kills,
  output logic [3:0] wave,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, COUNT, PICK, SPAWN, WAIT} state_t;

  state_t      state, state_nx;
  logic [7:0]  counter, counter_nx;
  logic [1:0]  wait_cnt, wait_cnt_nx;
  logic [2:0]  slot, slot_nx;
  logic [15:0] lfsr;
  logic [2:0]  expl_prev;

  logic [7:0]  base, wave_x4, interval;
  logic [8:0]  diff;

  // Subtraction is done 9 bits wide so an underflow shows up as a borrow and clamps.
  always_comb begin
    case (difficulty)
      3'b001:  base = INT_EASY;
      3'b100:  base = INT_HARD;
      default: base = INT_NORMAL;
    endcase
    wave_x4  = {2'b00, wave, 2'b00};
    diff     = {1'b0, base} - {1'b0, wave_x4};
    interval = (diff[8] || (diff[7:0] < INT_FLOOR)) ? INT_FLOOR : diff[7:0];
  end

  logic [1:0] start, s1, s2, n_found, limit;
  logic [2:0] pick_mask;

  always_comb begin
    start = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
    s1    = (start == 2'd2) ? 2'd0 : start + 2'd1;
    s2    = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;
`ifdef FLYER_BURST_EN
    limit = (wave >= 4'd4) ? 2'd2 : 2'd1;
`else
    limit = 2'd1;
`endif
    pick_mask = '0;
    n_found   = '0;
    if (!flyer_exists[start]) begin
      pick_mask[start] = 1'b1;
      n_found          = n_found + 2'd1;
    end
    if (!flyer_exists[s1] && (n_found < limit)) begin
      pick_mask[s1] = 1'b1;
      n_found       = n_found + 2'd1;
    end
    if (!flyer_exists[s2] && (n_found < limit)) begin
      pick_mask[s2] = 1'b1;
      n_found       = n_found + 2'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    counter_nx  = counter;
    wait_cnt_nx = wait_cnt;
    slot_nx     = slot;
    if (!run) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          counter_nx = interval;
          state_nx   = COUNT;
        end
        COUNT: begin
          if (counter == '0) state_nx = PICK;
          else               counter_nx = counter - 8'd1;
        end
        PICK: begin
          if (pick_mask != '0) begin
            slot_nx  = pick_mask;
            state_nx = SPAWN;
          end else begin
            counter_nx = '0;
            state_nx   = COUNT;
          end
        end
        SPAWN: begin
          wait_cnt_nx = 2'd3;
          state_nx    = WAIT;
        end
        WAIT: begin
          wait_cnt_nx = wait_cnt - 2'd1;
          if (((flyer_exists & slot) != '0) || (wait_cnt == 2'd1)) begin
            counter_nx = interval;
            state_nx   = COUNT;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic [2:0] rises;
  logic [1:0] n_rise;
  logic [8:0] ksum;
  logic [7:0] kills_nx;
  logic [3:0] wave_nx;

  // A wave step is a change in kills/8; saturation at 255 never crosses 256.
  always_comb begin
    rises    = flyer_explosion & ~expl_prev;
    n_rise   = {1'b0, rises[0]} + {1'b0, rises[1]} + {1'b0, rises[2]};
    ksum     = {1'b0, kills} + {7'b0, n_rise};
    kills_nx = kills;
    wave_nx  = wave;
    if (run) begin
      kills_nx = ksum[8] ? 8'hFF : ksum[7:0];
      if ((kills_nx[7:3] != kills[7:3]) && (wave != 4'hF))
        wave_nx = wave + 4'd1;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= '0;
      wait_cnt  <= '0;
      slot      <= '0;
      lfsr      <= LFSR_SEED;
      expl_prev <= '0;
      kills     <= '0;
      wave      <= '0;
      spawn     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      counter   <= counter_nx;
      wait_cnt  <= wait_cnt_nx;
      slot      <= slot_nx;
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      expl_prev <= flyer_explosion;
      kills     <= kills_nx;
      wave      <= wave_nx;
      spawn     <= (state_nx == SPAWN) ? slot_nx : '0;
      busy      <= (state_nx == PICK) || (state_nx == SPAWN) || (state_nx == WAIT);
    end
  end

endmodule

// File: tb/tb_flyer_spawner.sv
// Self-checking bench for flyer_spawner: frame-level behavioural model compared every
// frame, plus directed literal checks. Honours FLYER_BURST_EN when defined.
module tb_flyer_spawner;

  logic       Reset, frame_clk, run;
  logic [2:0] difficulty, flyer_exists, flyer_explosion;
  logic [2:0] spawn;
  logic [7:0] kills;
  logic [3:0] wave;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic echo   = 1'b0;

  flyer_spawner #(
    .INT_EASY(8'd120), .INT_NORMAL(8'd90), .INT_HARD(8'd60),
    .INT_FLOOR(8'd30), .LFSR_SEED(16'hACE1)
  ) dut (
    .Reset(Reset), .frame_clk(frame_clk), .run(run), .difficulty(difficulty),
    .flyer_exists(flyer_exists), .flyer_explosion(flyer_explosion),
    .spawn(spawn), .kills(kills), .wave(wave), .busy(busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 counting, 2 picking, 3 spawning, 4 waiting for acknowledge
  int         m_phase, m_cnt, m_wcnt, m_kills, m_wave;
  logic [2:0] m_mask, m_prev;
  logic [15:0] m_lfsr;

  function automatic int interval_of(input logic [2:0] d, input int w);
    int b;
    b = (d == 3'b001) ? 120 : (d == 3'b100) ? 60 : 90;
    b = b - 4 * w;
    return (b < 30) ? 30 : b;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_wcnt = 0; m_kills = 0; m_wave = 0;
    m_mask = '0; m_prev = '0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    int iv, st, n, lim, idx, nk;
    logic [2:0] pick, r;
    iv = interval_of(difficulty, m_wave);
    st = int'(m_lfsr[1:0]);
    if (st == 3) st = 0;
    if (!run) m_phase = 0;
    else begin
      case (m_phase)
        0: begin m_cnt = iv; m_phase = 1; end
        1: if (m_cnt == 0) m_phase = 2; else m_cnt = m_cnt - 1;
        2: begin
          pick = '0; n = 0;
`ifdef FLYER_BURST_EN
          lim = (m_wave >= 4) ? 2 : 1;
`else
          lim = 1;
`endif
          for (int k = 0; k < 3; k++) begin
            idx = (st + k) % 3;
            if (!flyer_exists[idx] && n < lim) begin pick[idx] = 1'b1; n++; end
          end
          if (n > 0) begin m_mask = pick; m_phase = 3; end
          else begin m_cnt = 0; m_phase = 1; end
        end
        3: begin m_wcnt = 3; m_phase = 4; end
        default: begin
          if ((flyer_exists & m_mask) != 0) begin m_cnt = iv; m_phase = 1; end
          else begin
            m_wcnt = m_wcnt - 1;
            if (m_wcnt == 0) begin m_cnt = iv; m_phase = 1; end
          end
        end
      endcase
    end
    r = flyer_explosion & ~m_prev;
    m_prev = flyer_explosion;
    if (run) begin
      nk = m_kills + $countones(r);
      if (nk > 255) nk = 255;
      if ((nk / 8 != m_kills / 8) && m_wave < 15) m_wave++;
      m_kills = nk;
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge frame_clk or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-frame comparison ----------------
  initial forever begin
    @(negedge frame_clk);
    if (chk_en) begin
      chk("spawn", int'(spawn), (m_phase == 3) ? int'(m_mask) : 0);
      chk("busy", int'(busy), (m_phase >= 2) ? 1 : 0);
      chk("kills", int'(kills), m_kills);
      chk("wave", int'(wave), m_wave);
`ifndef FLYER_BURST_EN
      chk("spawn_onehot", ($countones(spawn) <= 1) ? 1 : 0, 1);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge frame_clk);
    if (echo) flyer_exists = flyer_exists | spawn;
  endtask

  task automatic do_reset();
    Reset = 1'b1; run = 1'b0; echo = 1'b0;
    flyer_exists = '0; flyer_explosion = '0;
    tick(); tick();
    Reset = 1'b0;
  endtask

  // Sets run high and returns the number of frames until the first spawn pulse (-1 on timeout).
  task automatic frames_to_spawn(output int f, output logic [2:0] sp);
    f = -1; sp = '0;
    run = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (spawn != 0) begin f = k - 1; sp = spawn; break; end
    end
  endtask

  initial begin
    int t1, t2, nb, nsp, f, got;
    logic [2:0] sp;
    Reset = 1'b1; run = 1'b0; difficulty = 3'b010;
    flyer_exists = '0; flyer_explosion = '0;
    @(posedge frame_clk);
    tick();
    chk_en = 1'b1;
    chk("reset_spawn", int'(spawn), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_kills", int'(kills), 0);
    chk("reset_wave", int'(wave), 0);

    // first spawn with an acknowledging flyer
    do_reset(); difficulty = 3'b010; echo = 1'b1;
    t1 = -1; t2 = -1; nb = 0; sp = '0;
    run = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (busy && (t1 < 0 || k <= t1 + 5)) nb++;
      if (spawn != 0) begin
        if (t1 < 0) begin t1 = k; sp = spawn; end
        else begin t2 = k; break; end
      end
    end
    chk("first_spawn_frame", t1 - 1, 92);
    chk("first_spawn_bits", $countones(sp), 1);
    chk("busy_frames_ack", nb, 3);
    chk("respawn_gap_after_pulse", t2 - t1 - 1, 93);

    // all slots occupied, then slot 1 freed
    do_reset(); flyer_exists = 3'b111; run = 1'b1;
    nsp = 0;
    for (int k = 0; k < 120; k++) begin tick(); if (spawn != 0) nsp++; end
    chk("full_no_spawn", nsp, 0);
    flyer_exists = 3'b101; got = 0;
    for (int k = 0; k < 2; k++) begin tick(); if (spawn == 3'b010) got = 1; end
    chk("freed_slot1_spawn", got, 1);

    // no acknowledge: three WAIT frames then reload
    do_reset(); difficulty = 3'b010;
    frames_to_spawn(f, sp);
    chk("noack_first_spawn", f, 92);
    nb = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (busy) nb++; end
    chk("noack_wait_frames", nb, 3);
    chk("noack_kills", int'(kills), 0);

    // kills, wave and saturation
    do_reset(); difficulty = 3'b010; run = 1'b1;
    flyer_explosion = 3'b111; tick();
    chk("kills_plus3", int'(kills), 3);
    flyer_explosion = 3'b000; tick();
    flyer_explosion = 3'b111; tick();
    flyer_explosion = 3'b000; tick();
    flyer_explosion = 3'b001; tick();
    flyer_explosion = 3'b000; tick();
    chk("kills_7", int'(kills), 7);
    chk("wave_0_at_7", int'(wave), 0);
    flyer_explosion = 3'b010; tick();
    flyer_explosion = 3'b000;
    chk("kills_8", int'(kills), 8);
    chk("wave_1_at_8", int'(wave), 1);
    run = 1'b0; tick();
    frames_to_spawn(f, sp);
    chk("interval_86_spawn", f, 88);
    for (int k = 0; k < 90; k++) begin
      flyer_explosion = 3'b111; tick();
      flyer_explosion = 3'b000; tick();
    end
    chk("kills_sat_255", int'(kills), 255);
    chk("wave_sat_15", int'(wave), 15);

    // hard difficulty at wave 15 hits the floor
    difficulty = 3'b100; run = 1'b0; tick();
    frames_to_spawn(f, sp);
    chk("floor_30_spawn", f, 32);
`ifdef FLYER_BURST_EN
    chk("burst_two_bits", $countones(sp), 2);
`else
    chk("single_bit_spawn", $countones(sp), 1);
`endif
    for (int k = 0; k < 10; k++) tick();
    run = 1'b0; tick();
    chk("rundrop_spawn", int'(spawn), 0);
    chk("rundrop_busy", int'(busy), 0);
    chk("rundrop_kills", int'(kills), 255);
    frames_to_spawn(f, sp);
    chk("rundrop_idle_reload", f, 32);

    // reset asserted while waiting for an acknowledge
    do_reset(); difficulty = 3'b100;
    frames_to_spawn(f, sp);
    tick();
    chk("in_wait_busy", int'(busy), 1);
    Reset = 1'b1; #1;
    chk("midwait_reset_spawn", int'(spawn), 0);
    chk("midwait_reset_busy", int'(busy), 0);
    tick(); Reset = 1'b0;
    nsp = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (spawn != 0) nsp++; end
    chk("after_reset_no_spawn", nsp, 0);

    // randomized traffic
    do_reset(); run = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      echo = ($urandom_range(0, 3) != 0);
      run = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 99) == 0) difficulty = 3'($urandom_range(0, 7));
      flyer_explosion = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 19) == 0) flyer_exists = flyer_exists & ~(3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) flyer_exists = flyer_exists | (3'b001 << $urandom_range(0, 2));
      Reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    Reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
